tff_updown_counter: RTL and testbench

- Parametrised synchronous up/down counter built from a T flip-flop cell per bit.
- Extends the fixed 3-bit T-flip-flop counter to WIDTH bits, with:
  - a programmable modulus
  - direction control
  - count enable
  - synchronous clear and parallel load
  - terminal-count and wrap outputs
- Serves as the general event/divider counter for the sequential-circuits library.

---
 rtl/seq_pkg.sv | 13 +
 rtl/tff_cell.sv | 18 +
 rtl/tff_updown_counter.sv | 76 +++++++
 tb/tb_tff_updown_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and helpers for the sequential-circuits library
package seq_pkg;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DOWN = 1'b0;

   // Values at or above the modulus saturate to the last legal count.
   function automatic int unsigned clamp_mod(input int unsigned value,
                                             input int unsigned modulus);
      return (value < modulus) ? value : modulus - 1;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with asynchronous active-low reset
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   // Toggle on every rising edge where t is high; cleared while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 1'b0;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - modulo-N up/down counter built from T flip-flop cells
module tff_updown_counter
   import seq_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("tff_updown_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
      $error("tff_updown_counter: MODULUS out of range");
   end

   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] t;

   assign load_clamped = WIDTH'(clamp_mod(32'(load_val), MODULUS));

   // Prioritised next count: clear, then load, then enabled step, else hold.
   // An out-of-range count steps up to 0 and steps down by one.
   always_comb begin
      next_count = count;
      if (clear) begin
         next_count = '0;
      end else if (load) begin
         next_count = load_clamped;
      end else if (en) begin
         if (up == CNT_UP) begin
            next_count = (count >= MAX_CNT) ? '0 : count + WIDTH'(1);
         end else begin
            next_count = (count == '0) ? MAX_CNT : count - WIDTH'(1);
         end
      end
   end

   // Each cell flips exactly the bits that differ from the wanted next value.
   assign t = next_count ^ count;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .t     (t[i]),
         .q     (count[i])
      );
   end

   // Terminal count depends only on en, up and the current count.
   assign tc = en && ((up == CNT_UP) ? (count == MAX_CNT) : (count == '0));

   // One-cycle pulse after an edge that actually wrapped (clear/load suppress it).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap <= 1'b0;
      end else begin
         wrap <= tc && !clear && !load;
      end
   end

endmodule

// File: tb/tb_tff_updown_counter.sv
// tb/tb_tff_updown_counter.sv - self-checking bench for tff_updown_counter
module tb_tff_updown_counter;

   localparam int NINST = 3;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up;
   logic       clear;
   logic       load;
   logic [3:0] load_val;

   logic [3:0] dut_cnt  [NINST];
   logic       dut_tc   [NINST];
   logic       dut_wrap [NINST];

   int mods [NINST] = '{10, 16, 2};
   int m_cnt  [NINST];
   bit m_wrap [NINST];

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit en;
      bit up;
      bit clr;
      bit ld;
      int lv;
      int cnt;
      bit tc;
      bit wr;
   } vec_t;

   vec_t tbl[$];

   tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(dut_cnt[0]), .tc(dut_tc[0]), .wrap(dut_wrap[0]));

   tff_updown_counter #(.WIDTH(4)) u_m16 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(dut_cnt[1]), .tc(dut_tc[1]), .wrap(dut_wrap[1]));

   tff_updown_counter #(.WIDTH(4), .MODULUS(2)) u_m2 (
      .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count(dut_cnt[2]), .tc(dut_tc[2]), .wrap(dut_wrap[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_tc(int k);
      return en && (up ? (m_cnt[k] == mods[k] - 1) : (m_cnt[k] == 0));
   endfunction

   task automatic chk_tc_all();
      for (int k = 0; k < NINST; k++)
         chk($sformatf("tc_m%0d", mods[k]), int'(dut_tc[k]), int'(model_tc(k)));
   endtask

   task automatic chk_state_all();
      for (int k = 0; k < NINST; k++) begin
         chk($sformatf("count_m%0d", mods[k]), int'(dut_cnt[k]), m_cnt[k]);
         chk($sformatf("wrap_m%0d", mods[k]), int'(dut_wrap[k]), int'(m_wrap[k]));
      end
   endtask

   // Reference: modular arithmetic on plain integers, evaluated per edge.
   task automatic model_edge();
      for (int k = 0; k < NINST; k++) begin
         int md;
         md = mods[k];
         if (!reset) begin
            m_cnt[k]  = 0;
            m_wrap[k] = 0;
         end else begin
            m_wrap[k] = en && !clear && !load &&
                        (up ? (m_cnt[k] == md - 1) : (m_cnt[k] == 0));
            if (clear)      m_cnt[k] = 0;
            else if (load)  m_cnt[k] = (int'(load_val) < md) ? int'(load_val) : md - 1;
            else if (en)    m_cnt[k] = up ? (m_cnt[k] + 1) % md : (m_cnt[k] + md - 1) % md;
         end
      end
   endtask

   task automatic apply(input bit e, input bit u, input bit c, input bit l, input int v,
                        input bit has_exp, input int ecnt, input bit etc, input bit ewr);
      en = e; up = u; clear = c; load = l; load_val = 4'(v);
      #1;
      chk_tc_all();
      if (has_exp) chk("tbl_tc", int'(dut_tc[0]), int'(etc));
      @(posedge clk);
      model_edge();
      #1;
      chk_state_all();
      if (has_exp) begin
         chk("tbl_count", int'(dut_cnt[0]), ecnt);
         chk("tbl_wrap", int'(dut_wrap[0]), int'(ewr));
      end
   endtask

   initial begin
      int w16;
      int w2;

      reset = 1'b0; en = 1'b1; up = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
      for (int k = 0; k < NINST; k++) begin m_cnt[k] = 0; m_wrap[k] = 0; end

      // Reset state: count/wrap zero, tc follows en && !up.
      #1;
      chk_state_all();
      chk_tc_all();
      up = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_state_all();
      chk_tc_all();
      reset = 1'b1;

      // Directed vectors, expectations for the MODULUS=10 instance.
      for (int i = 1; i <= 12; i++)
         tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0, i % 10, (i == 10), (i == 10)});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2,  2, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  9, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  8, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5,  0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 13, 9, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4,  4, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0,  5, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0,  5, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  4, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 6,  6, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0,  7, 1'b0, 1'b0});

      foreach (tbl[i])
         apply(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].ld, tbl[i].lv,
               1'b1, tbl[i].cnt, tbl[i].tc, tbl[i].wr);

      // Async reset between edges: MODULUS=2 instance has wrap high here.
      chk("pre_reset_wrap_m2", int'(dut_wrap[2]), 1);
      #2 reset = 1'b0;
      #1;
      model_edge();
      chk_state_all();
      #2 reset = 1'b1;
      apply(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0);

      // Full-range sweep: clear, then 16 up edges.
      apply(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      w16 = 0;
      w2  = 0;
      for (int i = 0; i < 16; i++) begin
         apply(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
         w16 += int'(dut_wrap[1]);
         w2  += int'(dut_wrap[2]);
      end
      chk("m16_count_after_16", int'(dut_cnt[1]), 0);
      chk("m16_wrap_pulses", w16, 1);
      chk("m2_wrap_pulses", w2, 8);

      // MODULUS=2 consecutive wraps: up from 1, then down from 0.
      apply(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
      chk("m2_consecutive_wrap", int'(dut_wrap[2]), 1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         apply(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
               ($urandom % 12) == 0, int'($urandom % 16), 1'b0, 0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
